// File: rtl/irq_pkg.sv
// irq_pkg: shared constants for the platform interrupt controller.
//   Register offsets within the 256-byte window, the ID width used on the
//   core-facing irq_id port, and source-count limits.
package irq_pkg;

  localparam int ID_W    = 5;
  localparam int MAX_SRC = 31;

  localparam logic [7:0] OFF_PENDING   = 8'h00;
  localparam logic [7:0] OFF_ENABLE    = 8'h08;
  localparam logic [7:0] OFF_THRESHOLD = 8'h10;
  localparam logic [7:0] OFF_CLAIM     = 8'h18;
  localparam logic [7:0] OFF_TRIGGER   = 8'h20;
  localparam logic [7:0] OFF_PRIO_BASE = 8'h40;

  // Only this many 8-byte priority slots fit between OFF_PRIO_BASE and the
  // end of the window; sources beyond it keep priority 0 (never interrupt).
  localparam int PRIO_SLOTS = (256 - 64) / 8;

endpackage

// File: rtl/irq_gateway.sv
// irq_gateway: per-source pending / in-service tracking.
//   Optional feature macro: IRQ_EDGE_EN (adds edge_mode port and edge detect).
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   src             raw source line
//   edge_mode       1 = edge-triggered source (IRQ_EDGE_EN builds only)
//   claim           this ID is being claimed this cycle
//   complete        software completed this ID this cycle
//   pending         latched request
//   in_service      claimed and not yet completed
module irq_gateway (
  input  logic clk,
  input  logic reset,
  input  logic src,
`ifdef IRQ_EDGE_EN
  input  logic edge_mode,
`endif
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic in_service
);

  logic set_pending;

`ifdef IRQ_EDGE_EN
  logic src_q;

  always_ff @(posedge clk) begin
    if (!reset) src_q <= 1'b0;
    else        src_q <= src;
  end

  // Edge sources may re-pend while in service; only one edge is held.
  assign set_pending = edge_mode ? (src & ~src_q & ~pending)
                                 : (src & ~pending & ~in_service);
`else
  assign set_pending = src & ~pending & ~in_service;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending    <= 1'b0;
      in_service <= 1'b0;
    end else if (claim) begin
      // Claim beats a same-edge assertion of this source.
      pending    <= 1'b0;
      in_service <= 1'b1;
    end else begin
      if (set_pending) pending    <= 1'b1;
      if (complete)    in_service <= 1'b0;
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: platform interrupt controller with claim/complete register file.
//   Optional feature macro: IRQ_EDGE_EN (TRIGGER register, edge-mode sources).
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   src_irq           source lines, bit i = ID i+1
//   bus_address       core bus address (window at BASE_ADDR, 256 bytes)
//   bus_write_data    write data
//   bus_write_enable  single-cycle write strobe
//   bus_read_enable   single-cycle read strobe
//   bus_read_data     registered read data, held until the next read
//   irq_req           level request to the core
//   irq_id            registered winning ID, 0 when none
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int          NUM_SRC   = 8,
  parameter int          PRIO_W    = 3,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic [63:0]        bus_address,
  input  logic [63:0]        bus_write_data,
  input  logic               bus_write_enable,
  input  logic               bus_read_enable,
  output logic [63:0]        bus_read_data,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id
);

  logic [NUM_SRC-1:0] enable;
  logic [PRIO_W-1:0]  threshold;
  logic [PRIO_W-1:0]  prio [NUM_SRC];
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] in_service;
  logic [NUM_SRC-1:0] claim_vec;
  logic [NUM_SRC-1:0] complete_vec;
  logic [NUM_SRC-1:0] cand;
  logic [ID_W-1:0]    win_id;
  logic [PRIO_W-1:0]  win_prio;
  logic [63:0]        rd_mux;
  logic [7:0]         offset;
  logic               hit;
  logic               wr_en;
  logic               rd_en;

`ifdef IRQ_EDGE_EN
  logic [NUM_SRC-1:0] trigger;
`endif

  assign offset = bus_address[7:0];
  assign hit    = (bus_address[63:8] == BASE_ADDR[63:8]);
  assign wr_en  = bus_write_enable & hit;
  // A read colliding with a write returns 0 and must not claim.
  assign rd_en  = bus_read_enable & ~bus_write_enable & hit;

  always_comb begin
    claim_vec    = '0;
    complete_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_vec[i]    = rd_en && (offset == OFF_CLAIM) && (irq_id == ID_W'(i + 1));
      complete_vec[i] = wr_en && (offset == OFF_CLAIM) && (bus_write_data == 64'(i + 1));
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
    irq_gateway u_gw (
      .clk        (clk),
      .reset      (reset),
      .src        (src_irq[g]),
`ifdef IRQ_EDGE_EN
      .edge_mode  (trigger[g]),
`endif
      .claim      (claim_vec[g]),
      .complete   (complete_vec[g]),
      .pending    (pending[g]),
      .in_service (in_service[g])
    );
  end

  // The ID being claimed this edge is masked so irq_id cannot present it twice.
  assign cand = pending & enable & ~claim_vec;

  // Seeding the running maximum with the threshold enforces priority > threshold;
  // the strict compare leaves ties with the lowest ID.
  always_comb begin
    win_id   = '0;
    win_prio = threshold;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cand[i] && (prio[i] > win_prio)) begin
        win_prio = prio[i];
        win_id   = ID_W'(i + 1);
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (offset == OFF_PENDING)        rd_mux = 64'(pending);
    else if (offset == OFF_ENABLE)    rd_mux = 64'(enable);
    else if (offset == OFF_THRESHOLD) rd_mux = 64'(threshold);
    else if (offset == OFF_CLAIM)     rd_mux = 64'(irq_id);
`ifdef IRQ_EDGE_EN
    else if (offset == OFF_TRIGGER)   rd_mux = 64'(trigger);
`endif
    else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (i < PRIO_SLOTS && offset == OFF_PRIO_BASE + 8'(8 * i)) rd_mux = 64'(prio[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      enable        <= '0;
      threshold     <= '0;
      bus_read_data <= '0;
      irq_id        <= '0;
      for (int i = 0; i < NUM_SRC; i++) prio[i] <= '0;
`ifdef IRQ_EDGE_EN
      trigger       <= '0;
`endif
    end else begin
      if (wr_en) begin
        if (offset == OFF_ENABLE)    enable    <= bus_write_data[NUM_SRC-1:0];
        if (offset == OFF_THRESHOLD) threshold <= bus_write_data[PRIO_W-1:0];
`ifdef IRQ_EDGE_EN
        if (offset == OFF_TRIGGER)   trigger   <= bus_write_data[NUM_SRC-1:0];
`endif
        for (int i = 0; i < NUM_SRC; i++) begin
          if (i < PRIO_SLOTS && offset == OFF_PRIO_BASE + 8'(8 * i))
            prio[i] <= bus_write_data[PRIO_W-1:0];
        end
      end
      if (bus_read_enable) bus_read_data <= rd_en ? rd_mux : 64'd0;
      irq_id <= win_id;
    end
  end

  assign irq_req = (irq_id != '0);

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

  localparam logic [63:0] BASE = 64'h8000_0100;
  localparam int K_IDLE = 0;
  localparam int K_WR   = 1;
  localparam int K_RD   = 2;
  localparam int K_RW   = 3;

  logic        clk;
  logic        reset;
  logic [7:0]  src_irq;
  logic [63:0] bus_address;
  logic [63:0] bus_write_data;
  logic        bus_write_enable;
  logic        bus_read_enable;
  logic [63:0] bus_read_data;
  logic        irq_req;
  logic [4:0]  irq_id;

  int total = 0;
  int bad   = 0;

  irq_ctrl #(.NUM_SRC(8), .PRIO_W(3), .BASE_ADDR(BASE)) dut (
    .clk              (clk),
    .reset            (reset),
    .src_irq          (src_irq),
    .bus_address      (bus_address),
    .bus_write_data   (bus_write_data),
    .bus_write_enable (bus_write_enable),
    .bus_read_enable  (bus_read_enable),
    .bus_read_data    (bus_read_data),
    .irq_req          (irq_req),
    .irq_id           (irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [63:0] off;
    logic [63:0] wdata;
    logic [7:0]  src;
    logic [63:0] exp_rd;
    logic [4:0]  exp_id;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int kind, logic [63:0] off, logic [63:0] wdata,
                              logic [7:0] src, logic [63:0] exp_rd, logic [4:0] exp_id);
    vec_t v;
    v.kind = kind; v.off = off; v.wdata = wdata;
    v.src = src; v.exp_rd = exp_rd; v.exp_id = exp_id;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step(int kind, logic [63:0] off, logic [63:0] wdata, logic [7:0] src);
    src_irq          = src;
    bus_address      = BASE + off;
    bus_write_data   = wdata;
    bus_write_enable = (kind == K_WR) || (kind == K_RW);
    bus_read_enable  = (kind == K_RD) || (kind == K_RW);
    @(posedge clk); #1;
    bus_write_enable = 1'b0;
    bus_read_enable  = 1'b0;
  endtask

  task automatic check_irq(string name, logic [4:0] exp_id);
    check({name, ".id"}, 64'(irq_id), 64'(exp_id));
    check({name, ".req"}, 64'(irq_req), 64'(exp_id != 5'd0));
  endtask

  initial begin
    reset = 1'b0;
    src_irq = '0; bus_address = '0; bus_write_data = '0;
    bus_write_enable = 1'b0; bus_read_enable = 1'b0;

    // basic claim flow
    add(K_RD,   64'h00, 0, 8'h00, 64'h0, 0);
    add(K_RD,   64'h08, 0, 8'h00, 64'h0, 0);
    add(K_RD,   64'h18, 0, 8'h00, 64'h0, 0);
    add(K_WR,   64'h50, 2, 8'h00, 0, 0);
    add(K_WR,   64'h08, 64'h04, 8'h00, 0, 0);
    add(K_IDLE, 0, 0, 8'h04, 0, 0);
    add(K_IDLE, 0, 0, 8'h00, 0, 3);
    add(K_RD,   64'h00, 0, 8'h00, 64'h04, 3);
    add(K_RD,   64'h18, 0, 8'h00, 64'd3, 0);
    add(K_RD,   64'h00, 0, 8'h00, 64'h0, 0);
    add(K_WR,   64'h18, 3, 8'h00, 0, 0);
    add(K_RD,   64'h50, 0, 8'h00, 64'd2, 0);
    // priority ordering and tie-break
    add(K_WR,   64'h48, 5, 8'h00, 0, 0);
    add(K_WR,   64'h60, 5, 8'h00, 0, 0);
    add(K_WR,   64'h70, 6, 8'h00, 0, 0);
    add(K_WR,   64'h08, 64'h56, 8'h00, 0, 0);
    add(K_IDLE, 0, 0, 8'h52, 0, 0);
    add(K_IDLE, 0, 0, 8'h00, 0, 7);
    add(K_RD,   64'h18, 0, 8'h00, 64'd7, 2);
    add(K_WR,   64'h18, 7, 8'h00, 0, 2);
    add(K_RD,   64'h18, 0, 8'h00, 64'd2, 5);
    add(K_WR,   64'h18, 2, 8'h00, 0, 5);
    add(K_RD,   64'h18, 0, 8'h00, 64'd5, 0);
    add(K_WR,   64'h18, 5, 8'h00, 0, 0);
    // threshold
    add(K_WR,   64'h10, 4, 8'h00, 0, 0);
    add(K_WR,   64'h40, 4, 8'h00, 0, 0);
    add(K_WR,   64'h08, 64'h57, 8'h00, 0, 0);
    add(K_IDLE, 0, 0, 8'h01, 0, 0);
    add(K_IDLE, 0, 0, 8'h01, 0, 0);
    add(K_RD,   64'h10, 0, 8'h01, 64'd4, 0);
    add(K_WR,   64'h10, 3, 8'h01, 0, 0);
    add(K_IDLE, 0, 0, 8'h01, 0, 1);
    add(K_RD,   64'h18, 0, 8'h01, 64'd1, 0);
    add(K_WR,   64'h18, 1, 8'h00, 0, 0);
    add(K_WR,   64'h10, 0, 8'h00, 0, 0);
    // complete filtering and level re-pend
    add(K_WR,   64'h58, 3, 8'h00, 0, 0);
    add(K_WR,   64'h08, 64'h5F, 8'h00, 0, 0);
    add(K_IDLE, 0, 0, 8'h08, 0, 0);
    add(K_IDLE, 0, 0, 8'h08, 0, 4);
    add(K_RD,   64'h18, 0, 8'h08, 64'd4, 0);
    add(K_WR,   64'h18, 6, 8'h08, 0, 0);
    add(K_IDLE, 0, 0, 8'h08, 0, 0);
    add(K_RD,   64'h00, 0, 8'h08, 64'h0, 0);
    add(K_WR,   64'h18, 4, 8'h08, 0, 0);
    add(K_IDLE, 0, 0, 8'h08, 0, 0);
    add(K_IDLE, 0, 0, 8'h08, 0, 4);
    add(K_RD,   64'h00, 0, 8'h08, 64'h08, 4);
    // unmapped, out-of-range, high bits, read/write collision, off-window
    add(K_RD,   64'h28, 0, 8'h08, 64'h0, 4);
    add(K_RD,   64'h80, 0, 8'h08, 64'h0, 4);
    add(K_WR,   64'h08, 64'hFFFF_FFFF_FFFF_FF5F, 8'h08, 0, 4);
    add(K_RD,   64'h08, 0, 8'h08, 64'h5F, 4);
    add(K_RW,   64'h18, 0, 8'h08, 64'h0, 4);
    add(K_RD,   64'h00, 0, 8'h08, 64'h08, 4);
    add(K_RD,   64'h1018, 0, 8'h08, 64'h0, 4);
    add(K_RD,   64'h18, 0, 8'h08, 64'd4, 0);
    add(K_WR,   64'h18, 4, 8'h00, 0, 0);
    add(K_RD,   64'h08, 0, 8'h00, 64'h5F, 0);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_irq("reset", 5'd0);
    check("reset.rdata", bus_read_data, 64'h0);
    reset = 1'b1;

    foreach (vecs[n]) begin
      step(vecs[n].kind, vecs[n].off, vecs[n].wdata, vecs[n].src);
      if (vecs[n].kind == K_RD || vecs[n].kind == K_RW)
        check($sformatf("vec%0d.rdata", n), bus_read_data, vecs[n].exp_rd);
      check_irq($sformatf("vec%0d", n), vecs[n].exp_id);
    end

    // read data holds across idle cycles
    step(K_IDLE, 0, 0, 8'h00);
    step(K_IDLE, 0, 0, 8'h00);
    check("hold.rdata", bus_read_data, 64'h5F);

    // reset mid-write discards the access and clears state
    bus_address = BASE + 64'h08; bus_write_data = 64'hFF;
    bus_write_enable = 1'b1; src_irq = 8'h01;
    reset = 1'b0;
    @(posedge clk); #1;
    bus_write_enable = 1'b0; src_irq = 8'h00;
    @(posedge clk); #1;
    check_irq("midreset", 5'd0);
    check("midreset.rdata", bus_read_data, 64'h0);
    reset = 1'b1;
    step(K_RD, 64'h08, 0, 8'h00);
    check("midreset.enable", bus_read_data, 64'h0);
    step(K_RD, 64'h40, 0, 8'h00);
    check("midreset.prio1", bus_read_data, 64'h0);

`ifdef IRQ_EDGE_EN
    step(K_WR, 64'h40, 1, 8'h00);
    step(K_WR, 64'h08, 1, 8'h00);
    step(K_WR, 64'h20, 1, 8'h00);
    step(K_RD, 64'h20, 0, 8'h00);
    check("edge.trigger", bus_read_data, 64'h1);
    step(K_IDLE, 0, 0, 8'h01);
    step(K_IDLE, 0, 0, 8'h00);
    step(K_IDLE, 0, 0, 8'h01);
    step(K_IDLE, 0, 0, 8'h00);
    check_irq("edge.pend", 5'd1);
    step(K_RD, 64'h18, 0, 8'h00);
    check("edge.claim1", bus_read_data, 64'd1);
    check_irq("edge.after1", 5'd0);
    step(K_RD, 64'h18, 0, 8'h00);
    check("edge.claim2", bus_read_data, 64'd0);
`else
    step(K_WR, 64'h20, 1, 8'h00);
    step(K_RD, 64'h20, 0, 8'h00);
    check("trigger.absent", bus_read_data, 64'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
